// File: rtl/axi_bus_pkg.sv
// Shared definitions for the bus-side AXI read/write arbiters.
// Contents:
//   - field widths: master ID, address, data, burst length, burst type, response
//   - prefix_id(): forms a slave-side ID from {master index, master ID}
package axi_bus_pkg;

    localparam int MID_W     = 2;            // master-side ID width
    localparam int SID_W     = MID_W + 2;    // slave-side ID width for the default 4 masters
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 8;
    localparam int BURST_W   = 2;
    localparam int RESP_W    = 2;
    localparam int CNT_W     = 8;            // outstanding-burst counter width
    localparam int IDX_MAX_W = 8;            // widest master index prefix_id accepts

    // The caller keeps the low (index width + MID_W) bits of the result.
    function automatic logic [IDX_MAX_W+MID_W-1:0] prefix_id(
        input logic [IDX_MAX_W-1:0] idx,
        input logic [MID_W-1:0]     id
    );
        return {idx, id};
    endfunction

endpackage

// File: rtl/axi_bus_rd_arbiter_if.sv
// Read-channel bundle between the per-master bridges, the arbiter and the
// bus-side slave read port.
// Modports:
//   slave  - arbiter view: takes master AR / slave R, drives master R / slave AR
//   master - environment view: the mirror image of slave
// Handshake: every channel transfers one item on a cycle where VALID and READY
// are both high; VALID, once raised, is held with stable payload until READY.
interface axi_bus_rd_arbiter_if
    import axi_bus_pkg::*;
#(
    parameter int M_WIDTH = 2
);
    localparam int NM    = 1 << M_WIDTH;
    localparam int S_IDW = M_WIDTH + MID_W;

    logic [NM-1:0][MID_W-1:0]   M_B_RD_ADDR_ID;
    logic [NM-1:0][ADDR_W-1:0]  M_B_RD_ADDR;
    logic [NM-1:0][LEN_W-1:0]   M_B_RD_ADDR_LEN;
    logic [NM-1:0][BURST_W-1:0] M_B_RD_ADDR_BURST;
    logic [NM-1:0]              M_B_RD_ADDR_VALID;
    logic [NM-1:0]              M_B_RD_ADDR_READY;
    logic [NM-1:0][MID_W-1:0]   M_B_RD_BACK_ID;
    logic [NM-1:0][DATA_W-1:0]  M_B_RD_DATA;
    logic [NM-1:0][RESP_W-1:0]  M_B_RD_DATA_RESP;
    logic [NM-1:0]              M_B_RD_DATA_LAST;
    logic [NM-1:0]              M_B_RD_DATA_VALID;
    logic [NM-1:0]              M_B_RD_DATA_READY;

    logic [S_IDW-1:0]           S_B_RD_ADDR_ID;
    logic [ADDR_W-1:0]          S_B_RD_ADDR;
    logic [LEN_W-1:0]           S_B_RD_ADDR_LEN;
    logic [BURST_W-1:0]         S_B_RD_ADDR_BURST;
    logic                       S_B_RD_ADDR_VALID;
    logic                       S_B_RD_ADDR_READY;
    logic [S_IDW-1:0]           S_B_RD_BACK_ID;
    logic [DATA_W-1:0]          S_B_RD_DATA;
    logic [RESP_W-1:0]          S_B_RD_DATA_RESP;
    logic                       S_B_RD_DATA_LAST;
    logic                       S_B_RD_DATA_VALID;
    logic                       S_B_RD_DATA_READY;

    modport slave (
        input  M_B_RD_ADDR_ID, M_B_RD_ADDR, M_B_RD_ADDR_LEN, M_B_RD_ADDR_BURST,
               M_B_RD_ADDR_VALID, M_B_RD_DATA_READY,
               S_B_RD_ADDR_READY, S_B_RD_BACK_ID, S_B_RD_DATA, S_B_RD_DATA_RESP,
               S_B_RD_DATA_LAST, S_B_RD_DATA_VALID,
        output M_B_RD_ADDR_READY, M_B_RD_BACK_ID, M_B_RD_DATA, M_B_RD_DATA_RESP,
               M_B_RD_DATA_LAST, M_B_RD_DATA_VALID,
               S_B_RD_ADDR_ID, S_B_RD_ADDR, S_B_RD_ADDR_LEN, S_B_RD_ADDR_BURST,
               S_B_RD_ADDR_VALID, S_B_RD_DATA_READY
    );

    modport master (
        output M_B_RD_ADDR_ID, M_B_RD_ADDR, M_B_RD_ADDR_LEN, M_B_RD_ADDR_BURST,
               M_B_RD_ADDR_VALID, M_B_RD_DATA_READY,
               S_B_RD_ADDR_READY, S_B_RD_BACK_ID, S_B_RD_DATA, S_B_RD_DATA_RESP,
               S_B_RD_DATA_LAST, S_B_RD_DATA_VALID,
        input  M_B_RD_ADDR_READY, M_B_RD_BACK_ID, M_B_RD_DATA, M_B_RD_DATA_RESP,
               M_B_RD_DATA_LAST, M_B_RD_DATA_VALID,
               S_B_RD_ADDR_ID, S_B_RD_ADDR, S_B_RD_ADDR_LEN, S_B_RD_ADDR_BURST,
               S_B_RD_ADDR_VALID, S_B_RD_DATA_READY
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over 2**W requesters.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   req_i        - request vector
//   en_i         - a grant may be issued this cycle
//   gnt_o        - one-hot grant (zero when disabled or no request)
//   idx_o        - index of the winner (valid when hs_o)
//   hs_o         - a grant was issued, i.e. a handshake happens
//   ptr_o        - current priority pointer (observability)
// The search starts at the pointer and wraps; after a grant the pointer moves
// to one past the winner, and it holds when nothing is granted.
module rr_arbiter #(
    parameter int W = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [(1<<W)-1:0]   req_i,
    input  logic                en_i,
    output logic [(1<<W)-1:0]   gnt_o,
    output logic [W-1:0]        idx_o,
    output logic                hs_o,
    output logic [W-1:0]        ptr_o
);
    localparam int N = 1 << W;

    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] cand;
    logic         found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + W'(k);   // wraps naturally because N == 2**W
            if (!found && req_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
        hs_o  = en_i && found;
        gnt_o = hs_o ? (N'(1) << idx_o) : '0;
        ptr_d = hs_o ? idx_o + W'(1) : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/axi_bus_rd_arbiter.sv
// Bus-side read-channel arbiter: merges 2**M_WIDTH master AR channels into one
// registered slave AR channel (round-robin), widens the ID with the master
// index, routes R beats back by ID and caps outstanding bursts at MAX_OUT.
// Ports:
//   BUS_CLK, BUS_RST - bus clock, asynchronous active-high reset
//   bus              - read-channel bundle (slave modport)
//   dbg_rr_ptr_o     - round-robin pointer
//   dbg_out_cnt_o    - accepted-but-not-completed burst count
module axi_bus_rd_arbiter
    import axi_bus_pkg::*;
#(
    parameter int M_WIDTH = 2,
    parameter int MAX_OUT = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    axi_bus_rd_arbiter_if.slave  bus,
    output logic [M_WIDTH-1:0]   dbg_rr_ptr_o,
    output logic [CNT_W-1:0]     dbg_out_cnt_o
);
    localparam int NM    = 1 << M_WIDTH;
    localparam int S_IDW = M_WIDTH + MID_W;

    // AR output slot
    logic               s_valid_q, s_valid_d;
    logic [S_IDW-1:0]   s_id_q, s_id_d;
    logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
    logic [LEN_W-1:0]   s_len_q, s_len_d;
    logic [BURST_W-1:0] s_burst_q, s_burst_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic                      slot_free, can_accept, ar_hs;
    logic [NM-1:0]             gnt;
    logic [M_WIDTH-1:0]        win_idx;
    logic [IDX_MAX_W+MID_W-1:0] sid_full;
    logic [M_WIDTH-1:0]        r_idx;
    logic                      s_rready, r_done, dec;

    // The slot can take a new request when empty or being drained this cycle.
    assign slot_free  = !s_valid_q || bus.S_B_RD_ADDR_READY;
    assign can_accept = !BUS_RST && slot_free && (out_cnt_q < CNT_W'(MAX_OUT));

    rr_arbiter #(.W(M_WIDTH)) u_rr (
        .clk_i (BUS_CLK),
        .rst_i (BUS_RST),
        .req_i (bus.M_B_RD_ADDR_VALID),
        .en_i  (can_accept),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .hs_o  (ar_hs),
        .ptr_o (dbg_rr_ptr_o)
    );

    assign bus.M_B_RD_ADDR_READY = gnt;
    assign sid_full = prefix_id(IDX_MAX_W'(win_idx), bus.M_B_RD_ADDR_ID[win_idx]);

    always_comb begin
        s_valid_d = s_valid_q;
        s_id_d    = s_id_q;
        s_addr_d  = s_addr_q;
        s_len_d   = s_len_q;
        s_burst_d = s_burst_q;
        if (ar_hs) begin
            s_valid_d = 1'b1;
            s_id_d    = sid_full[S_IDW-1:0];
            s_addr_d  = bus.M_B_RD_ADDR[win_idx];
            s_len_d   = bus.M_B_RD_ADDR_LEN[win_idx];
            s_burst_d = bus.M_B_RD_ADDR_BURST[win_idx];
        end else if (bus.S_B_RD_ADDR_READY) begin
            s_valid_d = 1'b0;   // drained with no refill
        end
    end

    // R routing: select the owning master from the index bits of the ID.
    assign r_idx    = bus.S_B_RD_BACK_ID[S_IDW-1:MID_W];
    assign s_rready = bus.M_B_RD_DATA_READY[r_idx];
    assign bus.S_B_RD_DATA_READY = s_rready;

    always_comb begin
        bus.M_B_RD_DATA_VALID        = '0;
        bus.M_B_RD_DATA_VALID[r_idx] = bus.S_B_RD_DATA_VALID;
        for (int i = 0; i < NM; i++) begin
            bus.M_B_RD_BACK_ID[i]   = bus.S_B_RD_BACK_ID[MID_W-1:0];
            bus.M_B_RD_DATA[i]      = bus.S_B_RD_DATA;
            bus.M_B_RD_DATA_RESP[i] = bus.S_B_RD_DATA_RESP;
            bus.M_B_RD_DATA_LAST[i] = bus.S_B_RD_DATA_LAST;
        end
    end

    // Outstanding bursts; a stray LAST with nothing outstanding is ignored.
    assign r_done = bus.S_B_RD_DATA_VALID && s_rready && bus.S_B_RD_DATA_LAST;
    assign dec    = r_done && (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (ar_hs && !dec)      out_cnt_d = out_cnt_q + CNT_W'(1);
        else if (!ar_hs && dec) out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            s_valid_q <= 1'b0;
            s_id_q    <= '0;
            s_addr_q  <= '0;
            s_len_q   <= '0;
            s_burst_q <= '0;
            out_cnt_q <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_id_q    <= s_id_d;
            s_addr_q  <= s_addr_d;
            s_len_q   <= s_len_d;
            s_burst_q <= s_burst_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign bus.S_B_RD_ADDR_VALID = s_valid_q;
    assign bus.S_B_RD_ADDR_ID    = s_id_q;
    assign bus.S_B_RD_ADDR       = s_addr_q;
    assign bus.S_B_RD_ADDR_LEN   = s_len_q;
    assign bus.S_B_RD_ADDR_BURST = s_burst_q;
    assign dbg_out_cnt_o         = out_cnt_q;

endmodule

// File: tb/tb_axi_bus_rd_arbiter.sv
// Directed bench for axi_bus_rd_arbiter: a MAX_OUT=8 instance for single,
// round-robin, stall, R routing and reset cases, and a MAX_OUT=2 instance for
// the outstanding cap.
module tb_axi_bus_rd_arbiter;

    logic clk;
    logic rst;

    axi_bus_rd_arbiter_if #(.M_WIDTH(2)) bus ();
    axi_bus_rd_arbiter_if #(.M_WIDTH(2)) cbus ();

    logic [1:0] ptr_a, ptr_c;
    logic [7:0] cnt_a, cnt_c;

    axi_bus_rd_arbiter #(.M_WIDTH(2), .MAX_OUT(8)) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .bus           (bus.slave),
        .dbg_rr_ptr_o  (ptr_a),
        .dbg_out_cnt_o (cnt_a)
    );

    axi_bus_rd_arbiter #(.M_WIDTH(2), .MAX_OUT(2)) dut_cap (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .bus           (cbus.slave),
        .dbg_rr_ptr_o  (ptr_c),
        .dbg_out_cnt_o (cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.M_B_RD_ADDR_ID = '0;    bus.M_B_RD_ADDR = '0;
        bus.M_B_RD_ADDR_LEN = '0;   bus.M_B_RD_ADDR_BURST = '0;
        bus.M_B_RD_ADDR_VALID = '0; bus.M_B_RD_DATA_READY = '0;
        bus.S_B_RD_ADDR_READY = 1'b0; bus.S_B_RD_BACK_ID = '0;
        bus.S_B_RD_DATA = '0;       bus.S_B_RD_DATA_RESP = '0;
        bus.S_B_RD_DATA_LAST = 1'b0; bus.S_B_RD_DATA_VALID = 1'b0;
        cbus.M_B_RD_ADDR_ID = '0;    cbus.M_B_RD_ADDR = '0;
        cbus.M_B_RD_ADDR_LEN = '0;   cbus.M_B_RD_ADDR_BURST = '0;
        cbus.M_B_RD_ADDR_VALID = '0; cbus.M_B_RD_DATA_READY = '0;
        cbus.S_B_RD_ADDR_READY = 1'b0; cbus.S_B_RD_BACK_ID = '0;
        cbus.S_B_RD_DATA = '0;       cbus.S_B_RD_DATA_RESP = '0;
        cbus.S_B_RD_DATA_LAST = 1'b0; cbus.S_B_RD_DATA_VALID = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset state, with requests present
        #2;
        bus.M_B_RD_ADDR_VALID = 4'hF;
        #1;
        chk("rst_ready", bus.M_B_RD_ADDR_READY, 4'h0);
        chk("rst_svalid", bus.S_B_RD_ADDR_VALID, 1'b0);
        chk("rst_sid", bus.S_B_RD_ADDR_ID, 4'h0);
        chk("rst_cnt", cnt_a, 8'd0);
        chk("rst_ptr", ptr_a, 2'd0);
        bus.M_B_RD_ADDR_VALID = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request from master 2
        bus.S_B_RD_ADDR_READY = 1'b1;
        bus.M_B_RD_ADDR_ID[2] = 2'd1;
        bus.M_B_RD_ADDR[2] = 32'h0000_1000;
        bus.M_B_RD_ADDR_LEN[2] = 8'd3;
        bus.M_B_RD_ADDR_BURST[2] = 2'd1;
        bus.M_B_RD_ADDR_VALID = 4'b0100;
        #1;
        chk("single_ready", bus.M_B_RD_ADDR_READY, 4'b0100);
        tick();
        bus.M_B_RD_ADDR_VALID = 4'b0000;
        chk("single_svalid", bus.S_B_RD_ADDR_VALID, 1'b1);
        chk("single_sid", bus.S_B_RD_ADDR_ID, 4'b1001);
        chk("single_addr", bus.S_B_RD_ADDR, 32'h0000_1000);
        chk("single_len", bus.S_B_RD_ADDR_LEN, 8'd3);
        chk("single_burst", bus.S_B_RD_ADDR_BURST, 2'd1);
        chk("single_cnt", cnt_a, 8'd1);
        chk("single_ptr", ptr_a, 2'd3);
        tick();
        chk("drain_svalid", bus.S_B_RD_ADDR_VALID, 1'b0);
        chk("noreq_ptr", ptr_a, 2'd3);

        // Master 3 alone brings the pointer back to 0
        bus.M_B_RD_ADDR_ID[3] = 2'd3;
        bus.M_B_RD_ADDR[3] = 32'hA000_0003;
        bus.M_B_RD_ADDR_VALID = 4'b1000;
        #1;
        chk("m3_ready", bus.M_B_RD_ADDR_READY, 4'b1000);
        tick();
        chk("m3_ptr", ptr_a, 2'd0);
        chk("m3_cnt", cnt_a, 8'd2);

        // Round-robin with all four requesting
        for (int i = 0; i < 4; i++) begin
            bus.M_B_RD_ADDR_ID[i] = 2'(i);
            bus.M_B_RD_ADDR[i] = 32'hA000_0000 + 32'(i);
            bus.M_B_RD_ADDR_LEN[i] = 8'(i);
        end
        bus.M_B_RD_ADDR_VALID = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            #1;
            chk("rr_ready", bus.M_B_RD_ADDR_READY, 64'(4'b0001 << e));
            tick();
            chk("rr_sid", bus.S_B_RD_ADDR_ID, 64'(e * 5));
            chk("rr_addr", bus.S_B_RD_ADDR, 64'(32'hA000_0000 + 32'(e)));
        end
        chk("rr_cnt", cnt_a, 8'd7);

        // Slave stall: slot holds master 0's request
        bus.S_B_RD_ADDR_READY = 1'b0;
        #1;
        chk("stall_ready0", bus.M_B_RD_ADDR_READY, 4'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_addr", bus.S_B_RD_ADDR, 32'hA000_0000);
            chk("stall_sid", bus.S_B_RD_ADDR_ID, 4'h0);
            chk("stall_svalid", bus.S_B_RD_ADDR_VALID, 1'b1);
            chk("stall_ready", bus.M_B_RD_ADDR_READY, 4'h0);
        end
        bus.S_B_RD_ADDR_READY = 1'b1;
        #1;
        chk("refill_ready", bus.M_B_RD_ADDR_READY, 4'b0010);
        tick();
        chk("refill_sid", bus.S_B_RD_ADDR_ID, 4'b0101);
        chk("refill_cnt", cnt_a, 8'd8);
        chk("cap8_ready", bus.M_B_RD_ADDR_READY, 4'h0);
        bus.M_B_RD_ADDR_VALID = 4'h0;
        tick();
        chk("cap8_svalid", bus.S_B_RD_ADDR_VALID, 1'b0);

        // R routing to master 3, four beats, back-pressure on the last one
        bus.S_B_RD_BACK_ID = 4'b1110;
        bus.S_B_RD_DATA_VALID = 1'b1;
        bus.M_B_RD_DATA_READY = 4'hF;
        for (int b = 0; b < 4; b++) begin
            bus.S_B_RD_DATA = 32'hD000_0000 + 32'(b);
            bus.S_B_RD_DATA_LAST = (b == 3);
            if (b == 3) begin
                bus.M_B_RD_DATA_READY[3] = 1'b0;
                #1;
                chk("r_bp_sready", bus.S_B_RD_DATA_READY, 1'b0);
                chk("r_bp_mvalid", bus.M_B_RD_DATA_VALID, 4'b1000);
                tick();
                chk("r_bp_cnt", cnt_a, 8'd8);
                bus.M_B_RD_DATA_READY[3] = 1'b1;
            end
            #1;
            chk("r_mvalid", bus.M_B_RD_DATA_VALID, 4'b1000);
            chk("r_backid3", bus.M_B_RD_BACK_ID[3], 2'b10);
            chk("r_backid0", bus.M_B_RD_BACK_ID[0], 2'b10);
            chk("r_data3", bus.M_B_RD_DATA[3], 64'(32'hD000_0000 + 32'(b)));
            chk("r_sready", bus.S_B_RD_DATA_READY, 1'b1);
            tick();
            if (b < 3) chk("r_mid_cnt", cnt_a, 8'd8);
        end
        chk("r_last_cnt", cnt_a, 8'd7);
        bus.S_B_RD_DATA_VALID = 1'b0;
        bus.S_B_RD_DATA_LAST = 1'b0;
        #1;
        chk("r_idle_mvalid", bus.M_B_RD_DATA_VALID, 4'h0);

        // Simultaneous AR accept and R last
        bus.M_B_RD_ADDR_VALID = 4'b0010;
        bus.S_B_RD_BACK_ID = 4'b0111;
        bus.S_B_RD_DATA_VALID = 1'b1;
        bus.S_B_RD_DATA_LAST = 1'b1;
        #1;
        chk("sim_ready", bus.M_B_RD_ADDR_READY, 4'b0010);
        chk("sim_mvalid", bus.M_B_RD_DATA_VALID, 4'b0010);
        tick();
        chk("sim_cnt", cnt_a, 8'd7);
        chk("sim_svalid", bus.S_B_RD_ADDR_VALID, 1'b1);
        chk("sim_sid", bus.S_B_RD_ADDR_ID, 4'b0101);
        chk("sim_ptr", ptr_a, 2'd2);
        bus.M_B_RD_ADDR_VALID = 4'h0;
        bus.S_B_RD_DATA_VALID = 1'b0;

        // Asynchronous reset mid-cycle
        #1 rst = 1'b1;
        #1;
        chk("arst_svalid", bus.S_B_RD_ADDR_VALID, 1'b0);
        chk("arst_cnt", cnt_a, 8'd0);
        chk("arst_ptr", ptr_a, 2'd0);
        chk("arst_sid", bus.S_B_RD_ADDR_ID, 4'h0);
        chk("arst_addr", bus.S_B_RD_ADDR, 32'h0);
        tick();
        rst = 1'b0;

        // Stray R last after reset: routed, counter stays at 0
        bus.S_B_RD_BACK_ID = 4'b0010;
        bus.S_B_RD_DATA_VALID = 1'b1;
        bus.S_B_RD_DATA_LAST = 1'b1;
        #1;
        chk("stray_mvalid", bus.M_B_RD_DATA_VALID, 4'b0001);
        tick();
        chk("stray_cnt", cnt_a, 8'd0);
        bus.S_B_RD_DATA_VALID = 1'b0;

        // Outstanding cap on the MAX_OUT=2 instance
        cbus.S_B_RD_ADDR_READY = 1'b1;
        cbus.M_B_RD_DATA_READY = 4'hF;
        cbus.M_B_RD_ADDR_ID[2] = 2'd3;
        cbus.M_B_RD_ADDR_VALID = 4'b0111;
        #1;
        chk("cap_g0", cbus.M_B_RD_ADDR_READY, 4'b0001);
        tick();
        chk("cap_g1", cbus.M_B_RD_ADDR_READY, 4'b0010);
        tick();
        chk("cap_full_cnt", cnt_c, 8'd2);
        for (int k = 0; k < 4; k++) begin
            chk("cap_blocked", cbus.M_B_RD_ADDR_READY, 4'h0);
            tick();
        end
        chk("cap_hold_cnt", cnt_c, 8'd2);
        cbus.S_B_RD_BACK_ID = 4'b0000;
        cbus.S_B_RD_DATA_VALID = 1'b1;
        cbus.S_B_RD_DATA_LAST = 1'b1;
        #1;
        chk("cap_rlast_ready", cbus.M_B_RD_ADDR_READY, 4'h0);
        tick();
        cbus.S_B_RD_DATA_VALID = 1'b0;
        cbus.S_B_RD_DATA_LAST = 1'b0;
        chk("cap_freed_cnt", cnt_c, 8'd1);
        #1;
        chk("cap_g2", cbus.M_B_RD_ADDR_READY, 4'b0100);
        tick();
        chk("cap_g2_sid", cbus.S_B_RD_ADDR_ID, 4'b1011);
        chk("cap_g2_cnt", cnt_c, 8'd2);
        cbus.M_B_RD_ADDR_VALID = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_bus_rd_arbiter.md
Name: axi_bus_rd_arbiter

Overview:
- Bus-side read-channel arbiter running on BUS_CLK.
- Sits directly downstream of the per-master clock-domain bridges and feeds one bus-side slave read port.
- Merges 2**M_WIDTH master AR channels into one slave AR channel using round-robin arbitration. It widens the 2-bit master ID to a 4-bit slave ID by prefixing the master index.
- Routes R beats back to the originating master by ID, and caps total outstanding read bursts.

Parameters:
- M_WIDTH, 2, log2 of master count; master index is M_WIDTH bits; slave ID width = M_WIDTH+2 (=4).
- MAX_OUT, 8, maximum accepted-but-not-completed read bursts, summed over all masters; legal range 1..255.

Ports:
- BUS_CLK  in  1  bus clock; the only clock.
- BUS_RST  in  1  reset, asynchronous, active-high.
- M_B_RD_ADDR_ID  in  [2**M_WIDTH][2]  per-master AR ID.
- M_B_RD_ADDR  in  [2**M_WIDTH][32]  per-master AR address.
- M_B_RD_ADDR_LEN  in  [2**M_WIDTH][8]  per-master burst length-1.
- M_B_RD_ADDR_BURST  in  [2**M_WIDTH][2]  per-master burst type.
- M_B_RD_ADDR_VALID  in  [2**M_WIDTH]  per-master AR valid.
- M_B_RD_ADDR_READY  out  [2**M_WIDTH]  per-master AR ready.
- M_B_RD_BACK_ID  out  [2**M_WIDTH][2]  R ID, lower 2 bits of slave ID.
- M_B_RD_DATA  out  [2**M_WIDTH][32]  R data.
- M_B_RD_DATA_RESP  out  [2**M_WIDTH][2]  R response.
- M_B_RD_DATA_LAST  out  [2**M_WIDTH]  R last.
- M_B_RD_DATA_VALID  out  [2**M_WIDTH]  R valid, one-hot or zero.
- M_B_RD_DATA_READY  in  [2**M_WIDTH]  R ready.
- S_B_RD_ADDR_ID  out  4  {master index, master ID}.
- S_B_RD_ADDR  out  32  slave AR address.
- S_B_RD_ADDR_LEN  out  8  slave AR length.
- S_B_RD_ADDR_BURST  out  2  slave AR burst type.
- S_B_RD_ADDR_VALID  out  1  slave AR valid, registered.
- S_B_RD_ADDR_READY  in  1  slave AR ready.
- S_B_RD_BACK_ID  in  4  slave R ID.
- S_B_RD_DATA  in  32  slave R data.
- S_B_RD_DATA_RESP  in  2  slave R response.
- S_B_RD_DATA_LAST  in  1  slave R last.
- S_B_RD_DATA_VALID  in  1  slave R valid.
- S_B_RD_DATA_READY  out  1  slave R ready.

Behaviour:
- Reset (BUS_RST=1, async):
  - S_B_RD_ADDR_VALID=0; S_B_RD_ADDR_ID/ADDR/LEN/BURST=0.
  - rr_ptr=0; out_cnt=0; all M_B_RD_ADDR_READY=0.
- AR slot:
  - One-entry output register. slot_free = !S_B_RD_ADDR_VALID | S_B_RD_ADDR_READY, so a drain and a refill may happen in the same cycle.
- Grant is combinational:
  - can_accept = slot_free & (out_cnt < MAX_OUT).
  - When can_accept, the winner is the first i with M_B_RD_ADDR_VALID[i] set, scanning from rr_ptr upward with wrap-around.
  - M_B_RD_ADDR_READY[winner]=1; all other READY bits are 0.
  - READY never depends on a different master's VALID except through the winner choice.
- On a master handshake:
  - Register S_B_RD_ADDR_ID <= {winner[M_WIDTH-1:0], M_B_RD_ADDR_ID[winner]} and copy ADDR/LEN/BURST.
  - S_B_RD_ADDR_VALID <= 1.
  - rr_ptr <= winner+1 mod 2**M_WIDTH.
  - Latency from master handshake to slave VALID is 1 cycle. Sustained throughput is 1 AR per cycle while the slave keeps READY high.
- Slave stall: while VALID=1 and READY=0, the register contents are held stable. VALID drops only after a handshake with no refill in the same cycle.
- No request: rr_ptr is unchanged.
- Outstanding counter out_cnt, width 8:
  - +1 on any master AR handshake.
  - −1 on S_B_RD_DATA_VALID & S_B_RD_DATA_READY & S_B_RD_DATA_LAST.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT.
  - If out_cnt=0, no decrement occurs even if the slave misbehaves; the counter saturates at 0.
- R routing (combinational, no state):
  - idx = S_B_RD_BACK_ID[3:2].
  - M_B_RD_DATA_VALID[idx] = S_B_RD_DATA_VALID; all other VALID bits are 0.
  - S_B_RD_DATA_READY = M_B_RD_DATA_READY[idx].
  - DATA/RESP/LAST and BACK_ID[1:0] are broadcast to all masters.
- Reset asserted mid-burst: all state clears immediately. Any in-flight R beats after reset release are routed normally but do not decrement below 0.

Decomposition:
- Shared package axi_bus_pkg holds:
  - Master ID width (2) and slave ID width (4).
  - ADDR/DATA/LEN/BURST widths.
  - The master-index-prefix function.
- One sub-module: rr_arbiter (request vector, enable, pointer update → one-hot grant plus index). It is reusable by the write-channel arbiter.

Test Plan:
- Single request: master 2 presents ID=1, ADDR=0x1000, LEN=3 with slave READY=1 → M_B_RD_ADDR_READY[2] high in the same cycle. Next cycle S_B_RD_ADDR_VALID=1 with ID=4'b1001, ADDR=0x1000, LEN=3.
- Round-robin: all 4 masters hold VALID with slave READY=1 → grants 0,1,2,3,0 on consecutive cycles; S_B_RD_ADDR_ID[3:2] follows 0,1,2,3,0.
- Slave stall: slave READY=0 for 5 cycles with masters requesting → S_B_RD_ADDR fields stay stable and all M READY=0. On READY=1, the next grant refills in the same cycle.
- Outstanding cap: MAX_OUT=2, two ARs accepted, no R → third master sees READY=0 indefinitely. One R beat with LAST=1 → third AR accepted the next cycle.
- R routing: slave returns ID=4'b1110, 4 beats, with LAST on beat 4 → only M_B_RD_DATA_VALID[3] toggles with BACK_ID=2'b10. Deasserting M_B_RD_DATA_READY[3] drops S_B_RD_DATA_READY; out_cnt decrements once.
- Simultaneous AR accept and R last, then BUS_RST pulsed mid-burst → out_cnt unchanged on the simultaneous cycle. After reset, VALID=0, out_cnt=0, rr_ptr=0.
